// File: rtl/poly_pair_loader.sv
// Assembles coefficient pairs into two N-word buffers; poly_valid rises 1 cycle after the final pair is accepted.
// in_ready drops while the buffers are presented and returns only after poly_ready is seen (single buffer, no overlap).
module poly_pair_loader #(
    parameter int          N     = 256,
    parameter int          WIDTH = 32,
    parameter int unsigned Q     = 8380417
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_last,
    output logic [N*WIDTH-1:0]       poly_a_flat,
    output logic [N*WIDTH-1:0]       poly_b_flat,
    output logic                     poly_valid,
    input  logic                     poly_ready,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     range_err,
    output logic                     len_err,
    input  logic                     err_clr
);
    localparam int CW = $clog2(N+1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [N*WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 range_err_q, range_err_d;
    logic                 len_err_q, len_err_d;

    logic accept;
    logic last_slot;
    logic range_set;
    logic len_set;

    assign accept    = in_valid && (state_q == FILL);
    assign last_slot = (count_q == CW'(N-1));
    assign range_set = accept && ((64'(in_a) >= 64'(Q)) || (64'(in_b) >= 64'(Q)));
    // A polynomial is malformed if in_last disagrees with whether this is slot N-1.
    assign len_set   = accept && (in_last != last_slot);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            a_q         <= '0;
            b_q         <= '0;
            count_q     <= '0;
            range_err_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            count_q     <= count_d;
            range_err_q <= range_err_d;
            len_err_q   <= len_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && (in_last || last_slot)) state_d = FULL;
            FULL:    if (poly_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == FILL);
        poly_valid = (state_q == FULL);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        count_d = count_q;
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (count_q == CW'(i)) begin
                    a_d[i*WIDTH +: WIDTH] = in_a;
                    b_d[i*WIDTH +: WIDTH] = in_b;
                end
            end
            count_d = count_q + CW'(1);
        end else if ((state_q == FULL) && poly_ready) begin
            a_d     = '0;
            b_d     = '0;
            count_d = '0;
        end
    end

    // A same-cycle set overrides err_clr.
    always_comb begin
        range_err_d = range_set ? 1'b1 : (err_clr ? 1'b0 : range_err_q);
        len_err_d   = len_set   ? 1'b1 : (err_clr ? 1'b0 : len_err_q);
    end

    assign poly_a_flat = a_q;
    assign poly_b_flat = b_q;
    assign count       = count_q;
    assign range_err   = range_err_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_poly_pair_loader.sv
// Randomised and directed bench for poly_pair_loader against an array-based reference model.
module tb_poly_pair_loader;
    localparam int          N  = 4;
    localparam int          W  = 8;
    localparam int unsigned Q  = 17;
    localparam int          CW = $clog2(N+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, in_valid, in_ready, in_last, poly_valid, poly_ready;
    logic           range_err, len_err, err_clr;
    logic [W-1:0]   in_a, in_b;
    logic [N*W-1:0] poly_a_flat, poly_b_flat;
    logic [CW-1:0]  count;

    poly_pair_loader #(.N(N), .WIDTH(W), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .poly_a_flat(poly_a_flat), .poly_b_flat(poly_b_flat),
        .poly_valid(poly_valid), .poly_ready(poly_ready), .count(count),
        .range_err(range_err), .len_err(len_err), .err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus a "presenting" flag.
    logic [W-1:0] ma[N];
    logic [W-1:0] mb[N];
    int           mcount;
    bit           mfull, mrerr, mlerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_flat(input bit sel_b);
        logic [63:0] f = '0;
        for (int i = 0; i < N; i++) f[i*W +: W] = sel_b ? mb[i] : ma[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        mcount = 0;
    endtask

    task automatic model_tick();
        bit rset = 0;
        bit lset = 0;
        if (!rst_n) begin
            model_clear();
            mfull = 0;
            mrerr = 0;
            mlerr = 0;
        end else begin
            if (!mfull && in_valid) begin
                ma[mcount] = in_a;
                mb[mcount] = in_b;
                if (in_a >= Q || in_b >= Q) rset = 1;
                if (in_last != (mcount == N-1)) lset = 1;
                mcount++;
                if (in_last || mcount == N) mfull = 1;
            end else if (mfull && poly_ready) begin
                model_clear();
                mfull = 0;
            end
            mrerr = rset ? 1'b1 : (err_clr ? 1'b0 : mrerr);
            mlerr = lset ? 1'b1 : (err_clr ? 1'b0 : mlerr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        chk("in_ready",   64'(in_ready),    64'(!mfull));
        chk("poly_valid", 64'(poly_valid),  64'(mfull));
        chk("count",      64'(count),       64'(mcount));
        chk("range_err",  64'(range_err),   64'(mrerr));
        chk("len_err",    64'(len_err),     64'(mlerr));
        chk("poly_a",     64'(poly_a_flat), model_flat(0));
        chk("poly_b",     64'(poly_b_flat), model_flat(1));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_poly();
        poly_ready = 1'b1;
        step();
        poly_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        poly_ready = 1'b0; err_clr = 1'b0;
        model_clear(); mfull = 0; mrerr = 0; mlerr = 0;
        step();
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(poly_valid), 64'd0);
        rst_n = 1'b1;

        // Full-length polynomial
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        chk("t1_valid", 64'(poly_valid), 64'd1);
        chk("t1_a", 64'(poly_a_flat), 64'h07050301);
        chk("t1_b", 64'(poly_b_flat), 64'h08060402);
        chk("t1_errs", 64'({range_err, len_err}), 64'd0);
        release_poly();
        chk("t1_rel_count", 64'(count), 64'd0);
        chk("t1_rel_a", 64'(poly_a_flat), 64'd0);

        // Short polynomial
        send(8'd1, 8'd2, 1'b0);
        send(8'd9, 8'd10, 1'b1);
        chk("t2_valid", 64'(poly_valid), 64'd1);
        chk("t2_a", 64'(poly_a_flat), 64'h00000901);
        chk("t2_len_err", 64'(len_err), 64'd1);
        release_poly();
        clear_errs();
        chk("t2_len_clr", 64'(len_err), 64'd0);

        // Out-of-range coefficient, then a run that overflows without in_last
        send(8'd17, 8'd3, 1'b0);
        chk("t3_range_err", 64'(range_err), 64'd1);
        clear_errs();
        chk("t3_range_clr", 64'(range_err), 64'd0);
        send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        chk("t3_full", 64'(poly_valid), 64'd1);
        chk("t3_a", 64'(poly_a_flat), 64'h01010111);
        chk("t3_len_err", 64'(len_err), 64'd1);

        // Hold in FULL with upstream pushing
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_ready", 64'(in_ready), 64'd0);
            chk("t4_hold_a", 64'(poly_a_flat), 64'h01010111);
        end
        poly_ready = 1'b1;
        step();
        poly_ready = 1'b0;
        in_valid   = 1'b0;
        chk("t4_rel_count", 64'(count), 64'd0);
        chk("t4_rel_a", 64'(poly_a_flat), 64'd0);
        chk("t4_rel_ready", 64'(in_ready), 64'd1);
        clear_errs();

        // Reset mid-fill
        send(8'd2, 8'd2, 1'b0);
        send(8'd4, 8'd4, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valid", 64'(poly_valid), 64'd0);
        send(8'd11, 8'd12, 1'b0);
        send(8'd13, 8'd14, 1'b0);
        send(8'd15, 8'd16, 1'b0);
        send(8'd10, 8'd0, 1'b1);
        chk("t5_a", 64'(poly_a_flat), 64'h0A0F0D0B);
        chk("t5_b", 64'(poly_b_flat), 64'h00100E0C);
        release_poly();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_a       = W'($urandom_range(0, 20));
            in_b       = W'($urandom_range(0, 20));
            in_last    = ($urandom_range(0, 5) == 0);
            poly_ready = ($urandom_range(0, 2) == 0);
            err_clr    = ($urandom_range(0, 7) == 0);
            rst_n      = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
